// File: rtl/pe_nic.sv
// Single-packet NIC between a PE register port and a router PE port, with one buffer per direction.
// Latency: a packet captured from the router is readable 1 cycle later; a PE write can inject 1 cycle later.
// Backpressure: net_ri drops while the input buffer is full; injection waits for net_ro and a VC/polarity match.
module pe_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    localparam logic [1:0] ADDR_IN_DAT  = 2'b00;
    localparam logic [1:0] ADDR_IN_STS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DAT = 2'b10;
    localparam logic [1:0] ADDR_OUT_STS = 2'b11;

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  pe_rd;
    logic                  pe_in_pop;
    logic                  pe_out_push;
    logic                  in_capture;

    assign pe_rd       = nicEn & ~nicWrEn;
    assign pe_in_pop   = pe_rd & (addr == ADDR_IN_DAT);
    assign pe_out_push = nicEn & nicWrEn & (addr == ADDR_OUT_DAT);

    assign net_ri     = ~in_full;
    assign in_capture = net_si & ~in_full;

    // The router only accepts on the VC matching its current polarity.
    assign net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity);
    assign net_do = out_full ? out_buf : '0;

    always_comb begin
        d_out = '0;
        if (pe_rd) begin
            case (addr)
                ADDR_IN_DAT:  d_out = in_buf;
                ADDR_IN_STS:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STS: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:      d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf   <= '0;
            in_full  <= 1'b0;
            out_buf  <= '0;
            out_full <= 1'b0;
        end else begin
            // Capture can only happen while empty, so it never races a read-to-clear.
            if (in_capture) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (pe_in_pop) begin
                in_full <= 1'b0;
            end

            // A write landing on the send edge sees out_full=1 and is dropped.
            if (net_so) begin
                out_full <= 1'b0;
            end else if (pe_out_push && !out_full) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_nic.sv
// Directed bench for pe_nic: reset, receive, polarity-gated send, backpressure, write drop, mid-op reset.
module tb_pe_nic;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          nicEn;
    logic          nicWrEn;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_polarity;

    int n_vec = 0;
    int n_err = 0;

    pe_nic #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    // The router side must never offer a packet while the NIC is full.
    always @(negedge clk) begin
        if (!reset && net_si && !net_ri) begin
            n_err++;
            $display("FAIL protocol: net_si asserted while net_ri=%0b", net_ri);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_idle();
        nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
    endtask

    task automatic pe_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a; #1;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v; #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pe_idle(); net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        tick(); tick();
        reset = 1'b0; #1;
        n_vec++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL reset_net_ri got %0b exp 1", net_ri); end
        n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL reset_net_so got %0b exp 0", net_so); end
        n_vec++; if (net_do !== '0) begin n_err++; $display("FAIL reset_net_do got %h exp 0", net_do); end
        n_vec++; if (d_out !== '0) begin n_err++; $display("FAIL reset_d_out got %h exp 0", d_out); end
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL reset_in_full got %h exp 0", d_out); end
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL reset_out_full got %h exp 0", d_out); end
        pe_idle();
    endtask

    task automatic test_receive();
        net_si = 1'b1; net_di = 64'h0123_4567_89AB_CDEF; #1;
        n_vec++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL rx_ready_before got %0b exp 1", net_ri); end
        tick();
        net_si = 1'b0; net_di = '0; #1;
        n_vec++; if (net_ri !== 1'b0) begin n_err++; $display("FAIL rx_ready_full got %0b exp 0", net_ri); end
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd1) begin n_err++; $display("FAIL rx_status_full got %h exp 1", d_out); end
        pe_read(2'b00);
        n_vec++; if (d_out !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL rx_data got %h exp 0123456789abcdef", d_out); end
        tick();
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL rx_status_cleared got %h exp 0", d_out); end
        n_vec++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL rx_ready_after got %0b exp 1", net_ri); end
        // Stale read while empty: old data, no state change.
        pe_read(2'b00);
        n_vec++; if (d_out !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL rx_stale_data got %h exp 0123456789abcdef", d_out); end
        tick();
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL rx_stale_status got %h exp 0", d_out); end
        pe_idle();
    endtask

    task automatic test_send_polarity();
        net_ro = 1'b1; net_polarity = 1'b1;
        pe_write(2'b10, 64'h8000_0000_0000_0055);
        n_vec++; if (d_out !== '0) begin n_err++; $display("FAIL tx_write_dout got %h exp 0", d_out); end
        tick();
        pe_idle(); net_polarity = 1'b0; #1;
        n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL tx_vc_mismatch got %0b exp 0", net_so); end
        n_vec++; if (net_do !== 64'h8000_0000_0000_0055) begin n_err++; $display("FAIL tx_do_waiting got %h exp 8000000000000055", net_do); end
        tick();
        net_polarity = 1'b1; #1;
        n_vec++; if (net_so !== 1'b1) begin n_err++; $display("FAIL tx_vc_match got %0b exp 1", net_so); end
        n_vec++; if (net_do !== 64'h8000_0000_0000_0055) begin n_err++; $display("FAIL tx_do_send got %h exp 8000000000000055", net_do); end
        tick();
        net_polarity = 1'b0; #1;
        n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL tx_so_after got %0b exp 0", net_so); end
        n_vec++; if (net_do !== '0) begin n_err++; $display("FAIL tx_do_after got %h exp 0", net_do); end
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL tx_status_after got %h exp 0", d_out); end
        pe_idle();
    endtask

    task automatic test_backpressure();
        net_ro = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_00AA);
        tick();
        for (int i = 0; i < 5; i++) begin
            net_polarity = i[0];
            pe_read(2'b11);
            n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL bp_so_cycle%0d got %0b exp 0", i, net_so); end
            n_vec++; if (d_out !== 64'd1) begin n_err++; $display("FAIL bp_status_cycle%0d got %h exp 1", i, d_out); end
            tick();
        end
        pe_idle(); net_ro = 1'b1; net_polarity = 1'b1; #1;
        n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL bp_release_mismatch got %0b exp 0", net_so); end
        tick();
        net_polarity = 1'b0; #1;
        n_vec++; if (net_so !== 1'b1) begin n_err++; $display("FAIL bp_release_send got %0b exp 1", net_so); end
        n_vec++; if (net_do !== 64'h0000_0000_0000_00AA) begin n_err++; $display("FAIL bp_release_do got %h exp aa", net_do); end
        tick();
        net_polarity = 1'b1;
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL bp_status_after got %h exp 0", d_out); end
        pe_idle();
    endtask

    task automatic test_write_drop();
        net_ro = 1'b0; net_polarity = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_0077);
        tick();
        pe_write(2'b10, 64'h0000_0000_0000_1111);
        tick();
        pe_idle(); #1;
        n_vec++; if (net_do !== 64'h0000_0000_0000_0077) begin n_err++; $display("FAIL drop_held got %h exp 77", net_do); end
        net_ro = 1'b1; #1;
        n_vec++; if (net_so !== 1'b1) begin n_err++; $display("FAIL drop_send got %0b exp 1", net_so); end
        n_vec++; if (net_do !== 64'h0000_0000_0000_0077) begin n_err++; $display("FAIL drop_send_do got %h exp 77", net_do); end
        tick();
        n_vec++; if (net_so !== 1'b0 || net_do !== '0) begin n_err++; $display("FAIL drop_no_ghost got so=%0b do=%h exp so=0 do=0", net_so, net_do); end
    endtask

    task automatic test_back_to_back();
        // Write on the same edge as the outgoing transfer must be dropped.
        net_ro = 1'b0; net_polarity = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_00B0);
        tick();
        net_ro = 1'b1;
        pe_write(2'b10, 64'h0000_0000_0000_00C0);
        n_vec++; if (net_so !== 1'b1) begin n_err++; $display("FAIL b2b_send got %0b exp 1", net_so); end
        tick();
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL b2b_write_dropped got %h exp 0", d_out); end
        n_vec++; if (net_do !== '0) begin n_err++; $display("FAIL b2b_do got %h exp 0", net_do); end
        // Ignored writes and the write-only data register reading as zero.
        pe_write(2'b11, 64'h1);
        tick();
        pe_write(2'b01, 64'h1);
        tick();
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL reg_wr11_ignored got %h exp 0", d_out); end
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL reg_wr01_ignored got %h exp 0", d_out); end
        net_ro = 1'b0;
        pe_write(2'b10, 64'h0000_0000_0000_00D0);
        tick();
        pe_read(2'b10);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL reg_rd10_zero got %h exp 0", d_out); end
        pe_idle(); net_ro = 1'b1; #1;
        n_vec++; if (net_so !== 1'b1 || net_do !== 64'h0000_0000_0000_00D0) begin n_err++; $display("FAIL reg_drain got so=%0b do=%h exp so=1 do=d0", net_so, net_do); end
        tick();
    endtask

    task automatic test_reset_mid();
        net_ro = 1'b0; net_polarity = 1'b0;
        net_si = 1'b1; net_di = 64'h0000_0000_DEAD_BEEF;
        pe_write(2'b10, 64'h0000_0000_0000_0033);
        tick();
        net_si = 1'b0; pe_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0; net_ro = 1'b1; #1;
        n_vec++; if (net_ri !== 1'b1) begin n_err++; $display("FAIL rst_mid_ri got %0b exp 1", net_ri); end
        n_vec++; if (net_so !== 1'b0) begin n_err++; $display("FAIL rst_mid_so got %0b exp 0", net_so); end
        n_vec++; if (net_do !== '0) begin n_err++; $display("FAIL rst_mid_do got %h exp 0", net_do); end
        pe_read(2'b01);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL rst_mid_in_full got %h exp 0", d_out); end
        pe_read(2'b11);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL rst_mid_out_full got %h exp 0", d_out); end
        pe_read(2'b00);
        n_vec++; if (d_out !== 64'd0) begin n_err++; $display("FAIL rst_mid_in_buf got %h exp 0", d_out); end
        pe_idle();
        net_si = 1'b1; net_di = 64'hFEED_0000_0000_0001;
        pe_write(2'b10, 64'h0000_0000_0000_0044);
        tick();
        net_si = 1'b0; pe_read(2'b00);
        n_vec++; if (d_out !== 64'hFEED_0000_0000_0001) begin n_err++; $display("FAIL rst_mid_rx got %h exp feed000000000001", d_out); end
        n_vec++; if (net_so !== 1'b1 || net_do !== 64'h0000_0000_0000_0044) begin n_err++; $display("FAIL rst_mid_tx got so=%0b do=%h exp so=1 do=44", net_so, net_do); end
        tick();
        pe_idle(); #1;
        n_vec++; if (net_ri !== 1'b1 || net_so !== 1'b0) begin n_err++; $display("FAIL rst_mid_final got ri=%0b so=%0b exp ri=1 so=0", net_ri, net_so); end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_send_polarity();
        test_backpressure();
        test_write_drop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
